// File: rtl/scr1_pfq_pkg.sv
// Shared types and constants for the IFU prefetch queue.
package scr1_pfq_pkg;

  localparam int SCR1_IMEM_AWIDTH    = 32;
  localparam int SCR1_IMEM_DWIDTH    = 32;
  localparam int SCR1_PFQ_DEPTH      = 4;
  localparam int SCR1_PFQ_MAX_OUTST  = 2;
  localparam int SCR1_PFQ_PTR_W      = $clog2(SCR1_PFQ_DEPTH);
  localparam int SCR1_PFQ_OUTST_W    = $clog2(SCR1_PFQ_MAX_OUTST + 1);
  localparam int SCR1_PFQ_INSTR_STEP = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef struct packed {
    logic [SCR1_IMEM_DWIDTH-1:0] instr;
    logic                        err;
  } type_scr1_pfq_entry_s;

endpackage

// File: rtl/scr1_pipe_ifu_pfq_if.sv
// IMEM fetch port of the prefetch queue; master = PFQ, slave = memory.
interface scr1_pipe_ifu_pfq_if
  import scr1_pfq_pkg::*;
#(
  parameter int AWIDTH = SCR1_IMEM_AWIDTH,
  parameter int DWIDTH = SCR1_IMEM_DWIDTH
) ();

  logic                pfq2imem_req;
  type_scr1_mem_cmd_e  pfq2imem_cmd;
  logic [AWIDTH-1:0]   pfq2imem_addr;
  logic                imem2pfq_req_ack;
  logic [DWIDTH-1:0]   imem2pfq_rdata;
  type_scr1_mem_resp_e imem2pfq_resp;

  modport master (
    output pfq2imem_req, pfq2imem_cmd, pfq2imem_addr,
    input  imem2pfq_req_ack, imem2pfq_rdata, imem2pfq_resp
  );

  modport slave (
    input  pfq2imem_req, pfq2imem_cmd, pfq2imem_addr,
    output imem2pfq_req_ack, imem2pfq_rdata, imem2pfq_resp
  );

endinterface

// File: rtl/scr1_pfq_fifo.sv
// Generic circular buffer with flush; pointers carry an extra wrap bit for full/empty.
module scr1_pfq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = wdata_i;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/scr1_pipe_ifu_pfq.sv
// Instruction prefetch queue: sequential IMEM reads, credit-limited issue, flush with stale discard.
// Optional SCR1_PFQ_BYPASS_EN forwards a response straight to the IDU when the queue is empty.
module scr1_pipe_ifu_pfq
  import scr1_pfq_pkg::*;
#(
  parameter int DEPTH     = SCR1_PFQ_DEPTH,
  parameter int MAX_OUTST = SCR1_PFQ_MAX_OUTST,
  parameter int AWIDTH    = SCR1_IMEM_AWIDTH,
  parameter int DWIDTH    = SCR1_IMEM_DWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exu2pfq_new_pc_req_i,
  input  logic [AWIDTH-1:0]        exu2pfq_new_pc_i,
  input  logic                     pipe2pfq_stop_i,
  scr1_pipe_ifu_pfq_if.master      imem,
  output logic                     pfq2idu_vd_o,
  output logic [DWIDTH-1:0]        pfq2idu_instr_o,
  output logic                     pfq2idu_err_o,
  input  logic                     idu2pfq_rdy_i,
  output logic                     pfq2pipe_empty_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);
  localparam int CRED_W  = PTR_W + 2;

  logic               fetch_en_q, fetch_en_d;
  logic               err_stop_q, err_stop_d;
  logic [AWIDTH-1:0]  fetch_addr_q, fetch_addr_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic [OUTST_W-1:0] discard_q, discard_d;

  logic               flush;
  logic               req;
  logic               ack_fire;
  logic               resp_vld;
  logic               resp_err;
  logic               resp_drop;
  logic               resp_keep;
  logic               bypass;
  logic [CRED_W-1:0]  credit_used;

  logic               fifo_push;
  logic               fifo_pop;
  logic [DWIDTH:0]    fifo_rdata;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               unused_pc_lsb;
  assign unused_pc_lsb = ^exu2pfq_new_pc_i[1:0];

  assign flush     = exu2pfq_new_pc_req_i;
  assign resp_vld  = (imem.imem2pfq_resp != SCR1_MEM_RESP_NOTRDY);
  assign resp_err  = (imem.imem2pfq_resp == SCR1_MEM_RESP_RDY_ER);
  assign resp_drop = resp_vld && (discard_q != '0);
  // A response landing in the flush cycle belongs to the old stream.
  assign resp_keep = resp_vld && (discard_q == '0) && !flush;

  assign credit_used = CRED_W'(fifo_count) + CRED_W'(outst_q);

  assign req = fetch_en_q && !pipe2pfq_stop_i && !err_stop_q && !flush &&
               (credit_used < CRED_W'(DEPTH)) &&
               (outst_q < OUTST_W'(MAX_OUTST));
  assign ack_fire = req && imem.imem2pfq_req_ack;

`ifdef SCR1_PFQ_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && idu2pfq_rdy_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = resp_keep && !bypass;
  assign fifo_pop  = !fifo_empty && idu2pfq_rdy_i;

  assign imem.pfq2imem_req  = req;
  assign imem.pfq2imem_cmd  = SCR1_MEM_CMD_RD;
  assign imem.pfq2imem_addr = fetch_addr_q;

  assign pfq2idu_vd_o     = !fifo_empty || bypass;
  assign pfq2idu_instr_o  = bypass ? imem.imem2pfq_rdata : fifo_rdata[DWIDTH:1];
  assign pfq2idu_err_o    = bypass ? resp_err : fifo_rdata[0];
  assign pfq2pipe_empty_o = fifo_empty && (outst_q == '0) && (discard_q == '0);

  always_comb begin
    fetch_en_d   = fetch_en_q | flush;
    err_stop_d   = err_stop_q;
    fetch_addr_d = fetch_addr_q;
    outst_d      = outst_q + OUTST_W'(ack_fire) - OUTST_W'(resp_vld);
    discard_d    = discard_q - OUTST_W'(resp_drop);
    if (flush) begin
      fetch_addr_d = {exu2pfq_new_pc_i[AWIDTH-1:2], 2'b00};
      err_stop_d   = 1'b0;
      // Every request still in flight after this cycle is stale.
      discard_d    = outst_q - OUTST_W'(resp_vld);
    end else begin
      if (ack_fire) begin
        fetch_addr_d = fetch_addr_q + AWIDTH'(SCR1_PFQ_INSTR_STEP);
      end
      if (resp_keep && resp_err) begin
        err_stop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_en_q   <= 1'b0;
      err_stop_q   <= 1'b0;
      fetch_addr_q <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      fetch_en_q   <= fetch_en_d;
      err_stop_q   <= err_stop_d;
      fetch_addr_q <= fetch_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  scr1_pfq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DWIDTH + 1)
  ) i_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (fifo_push),
    .wdata_i ({imem.imem2pfq_rdata, resp_err}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue credit makes a push into a full queue impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_scr1_pipe_ifu_pfq.sv
// Directed bench for the prefetch queue with a small in-order IMEM model.
module tb_scr1_pipe_ifu_pfq;
  import scr1_pfq_pkg::*;

`ifdef SCR1_PFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_pc_req = 1'b0;
  logic [31:0] new_pc = '0;
  logic        stop = 1'b0;
  logic        rdy = 1'b0;
  logic        vd, err, empty;
  logic [31:0] instr;

  scr1_pipe_ifu_pfq_if imem_if ();

  scr1_pipe_ifu_pfq dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .exu2pfq_new_pc_req_i (new_pc_req),
    .exu2pfq_new_pc_i     (new_pc),
    .pipe2pfq_stop_i      (stop),
    .imem                 (imem_if),
    .pfq2idu_vd_o         (vd),
    .pfq2idu_instr_o      (instr),
    .pfq2idu_err_o        (err),
    .idu2pfq_rdy_i        (rdy),
    .pfq2pipe_empty_o     (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pend_q [$];
  logic [31:0] issued [$];
  logic [32:0] popped [$];
  logic        ack_en = 1'b1;
  logic        serial = 1'b0;
  logic        resp_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  logic        cap_ack, cap_resp, cap_pop;
  logic [31:0] cap_addr;
  logic [32:0] cap_pop_val;

  function automatic logic [31:0] data_of(logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check_val(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive memory side mid-cycle and capture what the coming edge will consume.
  task automatic drive();
    #1;
    if (resp_en && pend_q.size() > 0) begin
      imem_if.imem2pfq_resp  = (pend_q[0] == err_addr) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      imem_if.imem2pfq_rdata = data_of(pend_q[0]);
    end else begin
      imem_if.imem2pfq_resp  = SCR1_MEM_RESP_NOTRDY;
      imem_if.imem2pfq_rdata = '0;
    end
    imem_if.imem2pfq_req_ack = 1'b0;
    #1;
    imem_if.imem2pfq_req_ack = ack_en && imem_if.pfq2imem_req && (!serial || pend_q.size() == 0);
    #1;
    cap_ack     = imem_if.pfq2imem_req && imem_if.imem2pfq_req_ack;
    cap_addr    = imem_if.pfq2imem_addr;
    cap_resp    = (imem_if.imem2pfq_resp != SCR1_MEM_RESP_NOTRDY);
    cap_pop     = vd && rdy;
    cap_pop_val = {err, instr};
  endtask

  task automatic step();
    @(posedge clk);
    if (cap_ack) begin
      pend_q.push_back(cap_addr);
      issued.push_back(cap_addr);
    end
    if (cap_resp) void'(pend_q.pop_front());
    if (cap_pop) popped.push_back(cap_pop_val);
    #1;
  endtask

  task automatic tick();
    drive();
    step();
  endtask

  task automatic flush_to(logic [31:0] pc);
    new_pc_req = 1'b1;
    new_pc     = pc;
    stop       = 1'b0;
    drive();
    check_val("flush_req_gated", imem_if.pfq2imem_req, 0);
    step();
    new_pc_req = 1'b0;
  endtask

  task automatic quiesce(string tag);
    int n;
    n = 0;
    stop = 1'b1; rdy = 1'b1; resp_en = 1'b1; ack_en = 1'b1;
    drive();
    while (!empty && n < 40) begin
      step();
      drive();
      n++;
    end
    check_val(tag, empty, 1);
    step();
  endtask

  initial begin
    int vd_cnt;
    imem_if.imem2pfq_req_ack = 1'b0;
    imem_if.imem2pfq_rdata   = '0;
    imem_if.imem2pfq_resp    = SCR1_MEM_RESP_NOTRDY;
    #3;
    check_val("rst_req", imem_if.pfq2imem_req, 0);
    check_val("rst_vd", vd, 0);
    check_val("rst_err", err, 0);
    check_val("rst_instr", instr, 0);
    check_val("rst_empty", empty, 1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    drive();
    check_val("idle_no_fetch", imem_if.pfq2imem_req, 0);
    step();

    // Sequential streaming at 0x200
    issued.delete(); popped.delete(); rdy = 1'b1;
    flush_to(32'h200);
    drive();
    check_val("seq_req_c1", imem_if.pfq2imem_req, 1);
    check_val("seq_addr_c1", imem_if.pfq2imem_addr, 32'h200);
    step();
    drive();
    check_val("seq_vd_c2", vd, BYP);
    step();
    vd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive();
      if (vd) vd_cnt++;
      step();
    end
    check_val("seq_vd_every_cycle", vd_cnt, 6);
    check_val("seq_issue_order", issued[2], 32'h208);
    check_val("seq_pop0", popped[0], {1'b0, data_of(32'h200)});
    check_val("seq_pop5", popped[5], {1'b0, data_of(32'h214)});
    quiesce("seq_drain");

    // Backpressure: credit stops issue at 4
    issued.delete(); popped.delete(); rdy = 1'b0;
    flush_to(32'h300);
    repeat (10) tick();
    drive();
    check_val("bp_req_held", imem_if.pfq2imem_req, 0);
    check_val("bp_issued", issued.size(), 4);
    check_val("bp_vd", vd, 1);
    check_val("bp_head", instr, data_of(32'h300));
    check_val("bp_not_empty", empty, 0);
    step();
    rdy = 1'b1; tick(); rdy = 1'b0;
    drive();
    check_val("bp_req_after_pop", imem_if.pfq2imem_req, 1);
    step();
    quiesce("bp_drain");
    check_val("bp_pop_cnt", popped.size(), 5);
    check_val("bp_pop3", popped[3], {1'b0, data_of(32'h30C)});

    // Flush with two in flight; stale responses dropped
    issued.delete(); popped.delete(); rdy = 1'b1; resp_en = 1'b0;
    flush_to(32'h400);
    tick(); tick();
    drive();
    check_val("stale_outst_limit", imem_if.pfq2imem_req, 0);
    check_val("stale_issued", issued.size(), 2);
    step();
    flush_to(32'h1000);
    resp_en = 1'b1; popped.delete();
    drive();
    check_val("stale_empty_busy", empty, 0);
    step();
    repeat (8) tick();
    check_val("stale_pop0", popped[0], {1'b0, data_of(32'h1000)});
    check_val("stale_pop1", popped[1], {1'b0, data_of(32'h1004)});
    quiesce("stale_drain");

    // Access fault at 0x208 stops issue
    issued.delete(); popped.delete(); rdy = 1'b0; serial = 1'b1; err_addr = 32'h208;
    flush_to(32'h200);
    repeat (12) tick();
    drive();
    check_val("err_no_issue", imem_if.pfq2imem_req, 0);
    check_val("err_issued", issued.size(), 3);
    check_val("err_head_vd", vd, 1);
    check_val("err_head_clean", err, 0);
    step();
    rdy = 1'b1; repeat (4) tick(); rdy = 1'b0;
    check_val("err_pop_cnt", popped.size(), 3);
    check_val("err_pop0", popped[0], {1'b0, data_of(32'h200)});
    check_val("err_pop2", popped[2], {1'b1, data_of(32'h208)});
    drive();
    check_val("err_stop_held", imem_if.pfq2imem_req, 0);
    step();
    serial = 1'b0; err_addr = 32'hFFFF_FFF0;
    quiesce("err_drain");

    // WFI stop with one in flight; low address bits ignored
    issued.delete(); popped.delete(); rdy = 1'b0; resp_en = 1'b0;
    flush_to(32'h603);
    drive();
    check_val("stop_req_c1", imem_if.pfq2imem_req, 1);
    check_val("stop_addr_align", imem_if.pfq2imem_addr, 32'h600);
    step();
    stop = 1'b1;
    drive();
    check_val("stop_req_gated", imem_if.pfq2imem_req, 0);
    step();
    resp_en = 1'b1; tick();
    drive();
    check_val("stop_not_empty", empty, 0);
    check_val("stop_head", instr, data_of(32'h600));
    step();
    rdy = 1'b1; tick(); rdy = 1'b0;
    drive();
    check_val("stop_empty_after_pop", empty, 1);
    step();
    stop = 1'b0;
    drive();
    check_val("stop_resume_req", imem_if.pfq2imem_req, 1);
    check_val("stop_resume_addr", imem_if.pfq2imem_addr, 32'h604);
    step();
    quiesce("stop_drain");

    // Response-to-valid latency on an empty queue
    issued.delete(); popped.delete(); rdy = 1'b1; resp_en = 1'b0;
    flush_to(32'h700);
    tick();
    stop = 1'b1; resp_en = 1'b1;
    drive();
    check_val("lat_vd_resp_cycle", vd, BYP);
    step();
    drive();
    check_val("lat_vd_next", vd, !BYP);
    check_val("lat_empty_next", empty, BYP);
    step();
    tick();
    check_val("lat_pop0", popped[0], {1'b0, data_of(32'h700)});
    quiesce("lat_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
